// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: instruction input stream and immediate result stream.
// A beat moves on a rising edge where valid && ready; valid-side payload stays stable until taken.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry output buffer carrying a format tag per instruction.
// Optional RVC quadrant-1 decode is enabled by defining IMMGEN_RVC_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  imm_gen_if.slave bus
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CI    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [31:0]     instr;
  logic [XLEN-1:0] d_imm;
  logic [2:0]      d_fmt;
  logic            d_illegal;
  logic            is_shift;

  assign instr    = bus.in_instr;
  assign is_shift = (instr[13:12] == 2'b01);

  always_comb begin
    d_imm     = '0;
    d_fmt     = FMT_NONE;
    d_illegal = 1'b1;
    if (instr[1:0] != 2'b11) begin
`ifdef IMMGEN_RVC_EN
      if (instr[1:0] == 2'b01) begin
        case (instr[15:13])
          3'b000, 3'b010: begin
            d_imm     = sext32({{26{instr[12]}}, instr[12], instr[6:2]});
            d_fmt     = FMT_CI;
            d_illegal = 1'b0;
          end
          3'b011: begin
            if (instr[11:7] != 5'd0 && instr[11:7] != 5'd2) begin
              d_imm     = sext32({{14{instr[12]}}, instr[12], instr[6:2], 12'b0});
              d_fmt     = FMT_CI;
              d_illegal = 1'b0;
            end
          end
          3'b101: begin
            d_imm     = sext32({{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                                instr[7], instr[2], instr[11], instr[5:3], 1'b0});
            d_fmt     = FMT_CI;
            d_illegal = 1'b0;
          end
          3'b110, 3'b111: begin
            d_imm     = sext32({{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                                instr[11:10], instr[4:3], 1'b0});
            d_fmt     = FMT_CI;
            d_illegal = 1'b0;
          end
          default: ;
        endcase
      end
`else
      d_illegal = 1'b1;
`endif
    end else begin
      case (instr[6:0])
        7'b0000011, 7'b1100111, 7'b1110011: begin
          d_imm     = sext32({{20{instr[31]}}, instr[31:20]});
          d_fmt     = FMT_I;
          d_illegal = 1'b0;
        end
        7'b0010011: begin
          d_illegal = 1'b0;
          if (is_shift) begin
            d_fmt      = FMT_SHAMT;
            d_imm[4:0] = instr[24:20];
            if (XLEN == 64) d_imm[5] = instr[25];
          end else begin
            d_fmt = FMT_I;
            d_imm = sext32({{20{instr[31]}}, instr[31:20]});
          end
        end
        7'b0011011: begin
          // Word-sized OP-IMM exists only on RV64; shift amounts stay 5 bits.
          if (XLEN == 64) begin
            d_illegal = 1'b0;
            if (is_shift) begin
              d_fmt      = FMT_SHAMT;
              d_imm[4:0] = instr[24:20];
            end else begin
              d_fmt = FMT_I;
              d_imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
          end
        end
        7'b0100011: begin
          d_imm     = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
          d_fmt     = FMT_S;
          d_illegal = 1'b0;
        end
        7'b1100011: begin
          d_imm     = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0});
          d_fmt     = FMT_B;
          d_illegal = 1'b0;
        end
        7'b0110111, 7'b0010111: begin
          d_imm     = sext32({instr[31:12], 12'b0});
          d_fmt     = FMT_U;
          d_illegal = 1'b0;
        end
        7'b1101111: begin
          d_imm     = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0});
          d_fmt     = FMT_J;
          d_illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

  entry_t     head;
  entry_t     tail;
  entry_t     incoming;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign incoming = '{imm: d_imm, fmt: d_fmt, illegal: d_illegal, tag: bus.in_tag};

  // in_ready depends only on registered count (and reset), never on out_ready.
  assign bus.in_ready = !reset && (count != 2'd2);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= incoming;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= incoming;
          end else if (push) begin
            tail  <= incoming;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_illegal = head.illegal;
  assign bus.out_tag     = head.tag;

endmodule
